multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath: fetch/decode/execute/memory/write-back
// sequencing, bus timeout detection and a retired-instruction counter.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        imem_rvalid,
   input  logic        dmem_rvalid,
   input  logic        branch_taken,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic [1:0]  pc_src,
   output logic [2:0]  imm_sel,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic [1:0]  wb_sel,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic [6:0]  op_q;
   logic [6:0]  op_nxt;
   logic [6:0]  cur_op;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_nxt;
   logic [1:0]  cause_q;
   logic [1:0]  cause_nxt;

   logic        legal;
   logic [2:0]  dec_imm;
   logic        dec_a;
   logic        dec_b;
   logic [1:0]  dec_wb;

   logic        unused_instr_bits;
   assign unused_instr_bits = ^instr[31:12];

   // The opcode register is only loaded at the end of DECODE, so DECODE itself looks at the IR.
   assign cur_op = (state == DECODE) ? instr[6:0] : op_q;

   always_comb begin
      legal   = 1'b1;
      dec_imm = 3'd0;
      dec_a   = 1'b0;
      dec_b   = 1'b1;
      dec_wb  = 2'd0;
      case (cur_op)
         OP_LUI:    begin dec_imm = 3'd4; dec_wb = 2'd3; end
         OP_AUIPC:  begin dec_imm = 3'd4; dec_a = 1'b1; end
         OP_JAL:    begin dec_imm = 3'd5; dec_a = 1'b1; dec_wb = 2'd2; end
         OP_JALR:   begin dec_imm = 3'd1; dec_wb = 2'd2; end
         OP_BRANCH: begin dec_imm = 3'd3; dec_a = 1'b1; dec_b = 1'b0; end
         OP_LOAD:   begin dec_imm = 3'd1; dec_wb = 2'd1; end
         OP_STORE:  dec_imm = 3'd2;
         OP_OPIMM:  dec_imm = 3'd1;
         OP_OP:     dec_b = 1'b0;
         default: begin
            legal = 1'b0;
            dec_b = 1'b0;
         end
      endcase
   end

   always_comb begin
      next_state = state;
      op_nxt     = op_q;
      wait_nxt   = 8'd0;
      cause_nxt  = cause_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      pc_src     = 2'd0;
      imm_sel    = 3'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      wb_sel     = 2'd0;

      if (state != FETCH && state != TRAP) begin
         imm_sel   = dec_imm;
         alu_src_a = dec_a;
         alu_src_b = dec_b;
         wb_sel    = dec_wb;
      end

      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_rvalid) begin
               ir_we      = 1'b1;
               next_state = DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = TRAP;
               cause_nxt  = 2'd2;
            end else begin
               wait_nxt = wait_cnt + 8'd1;
            end
         end
         DECODE: begin
            op_nxt = instr[6:0];
            if (legal) begin
               next_state = EXEC;
            end else begin
               next_state = TRAP;
               cause_nxt  = 2'd1;
            end
         end
         EXEC: begin
            if (op_q == OP_LOAD || op_q == OP_STORE) begin
               next_state = MEM;
            end else if (op_q == OP_BRANCH) begin
               pc_we      = 1'b1;
               pc_src     = {1'b0, branch_taken};
               next_state = FETCH;
            end else begin
               next_state = WB;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op_q == OP_STORE);
            if (dmem_rvalid) begin
               if (op_q == OP_STORE) begin
                  pc_we      = 1'b1;
                  next_state = FETCH;
               end else begin
                  next_state = WB;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = TRAP;
               cause_nxt  = 2'd2;
            end else begin
               wait_nxt = wait_cnt + 8'd1;
            end
         end
         WB: begin
            pc_we      = 1'b1;
            reg_we     = (instr[11:7] != 5'd0);
            next_state = FETCH;
            if (op_q == OP_JAL) begin
               pc_src = 2'd1;
            end else if (op_q == OP_JALR) begin
               pc_src = 2'd2;
            end
         end
         default: begin
         end
      endcase

      // A transaction interrupted by reset must not commit anything.
      if (!rst_n) begin
         ir_we  = 1'b0;
         pc_we  = 1'b0;
         reg_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= FETCH;
         op_q     <= 7'd0;
         wait_cnt <= 8'd0;
         cause_q  <= 2'd0;
         instret  <= 32'd0;
      end else begin
         state    <= next_state;
         op_q     <= op_nxt;
         wait_cnt <= wait_nxt;
         cause_q  <= cause_nxt;
         if (pc_we) begin
            instret <= instret + 32'd1;
         end
      end
   end

   assign trap       = (state == TRAP);
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction's per-cycle output trace is
// derived from its opcode and chosen bus latencies, then compared against the DUT.
module tb_multicycle_ctrl;

   localparam int T = 16;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        imem_rvalid, dmem_rvalid, branch_taken;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
   logic [1:0]  pc_src;
   logic [2:0]  imm_sel;
   logic        alu_src_a, alu_src_b;
   logic [1:0]  wb_sel;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr),
      .imem_rvalid(imem_rvalid), .dmem_rvalid(dmem_rvalid), .branch_taken(branch_taken),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
      .pc_src(pc_src), .imm_sel(imm_sel),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
      .trap(trap), .trap_cause(trap_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n, irv, drv, bt, chk;
      logic       e_ireq, e_dreq, e_dwe, e_irwe, e_pcwe, e_regwe;
      logic [1:0] e_pcsrc;
      logic [2:0] e_imm;
      logic       e_a, e_b;
      logic [1:0] e_wb;
      logic       e_trap;
      logic [1:0] e_cause;
   } cyc_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc_idx;
   logic [31:0] model_instret = 32'd0;

   int          obs_pcwe_cycle, obs_dreq, obs_ireq;
   logic        obs_regwe;
   logic [1:0]  obs_pcsrc;
   logic        obs_first_ireq, obs_first_dreq;
   logic [31:0] obs_first_instret;

   function automatic void decodeOp(input logic [6:0] op, output logic [2:0] imm,
                                    output logic a, output logic b, output logic [1:0] wb,
                                    output logic legal);
      legal = 1'b1; imm = 3'd0; a = 1'b0; b = 1'b1; wb = 2'd0;
      case (op)
         OP_LUI:    begin imm = 3'd4; wb = 2'd3; end
         OP_AUIPC:  begin imm = 3'd4; a = 1'b1; end
         OP_JAL:    begin imm = 3'd5; a = 1'b1; wb = 2'd2; end
         OP_JALR:   begin imm = 3'd1; wb = 2'd2; end
         OP_BRANCH: begin imm = 3'd3; a = 1'b1; b = 1'b0; end
         OP_LOAD:   begin imm = 3'd1; wb = 2'd1; end
         OP_STORE:  imm = 3'd2;
         OP_OPIMM:  imm = 3'd1;
         OP_OP:     b = 1'b0;
         default:   begin legal = 1'b0; b = 1'b0; end
      endcase
   endfunction

   function automatic cyc_t blank();
      cyc_t c;
      c.rst_n = 1'b1; c.chk = 1'b1;
      c.irv = 1'($urandom_range(0, 1));
      c.drv = 1'($urandom_range(0, 1));
      c.bt  = 1'($urandom_range(0, 1));
      c.e_ireq = 0; c.e_dreq = 0; c.e_dwe = 0; c.e_irwe = 0; c.e_pcwe = 0; c.e_regwe = 0;
      c.e_pcsrc = 0; c.e_imm = 0; c.e_a = 0; c.e_b = 0; c.e_wb = 0; c.e_trap = 0; c.e_cause = 0;
      return c;
   endfunction

   function automatic cyc_t withFields(input cyc_t c, input logic [6:0] op);
      logic legal;
      decodeOp(op, c.e_imm, c.e_a, c.e_b, c.e_wb, legal);
      return c;
   endfunction

   task automatic checkLiteral(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic checkOutput(input cyc_t c);
      logic [17:0] got, exp;
      got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, pc_src, imm_sel,
             alu_src_a, alu_src_b, wb_sel, trap, trap_cause};
      exp = {c.e_ireq, c.e_dreq, c.e_dwe, c.e_irwe, c.e_pcwe, c.e_regwe, c.e_pcsrc, c.e_imm,
             c.e_a, c.e_b, c.e_wb, c.e_trap, c.e_cause};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL outputs t=%0t instr=%h cycle %0d: got %b expected %b",
                  $time, instr, cyc_idx, got, exp);
      end
      n_checks++;
      if (instret !== model_instret) begin
         n_fail++;
         $display("[TB] FAIL instret t=%0t: got %0d expected %0d", $time, instret, model_instret);
      end
      if (pc_we === 1'b1) begin
         if (obs_pcwe_cycle == 0) obs_pcwe_cycle = cyc_idx;
         obs_pcsrc = pc_src;
      end
      if (dmem_req === 1'b1) obs_dreq++;
      if (imem_req === 1'b1) obs_ireq++;
      if (reg_we === 1'b1) obs_regwe = 1'b1;
      if (cyc_idx == 1) begin
         obs_first_ireq    = imem_req;
         obs_first_dreq    = dmem_req;
         obs_first_instret = instret;
      end
   endtask

   // Inputs are driven just after a rising edge and outputs sampled on the falling edge.
   task automatic applyStimulus(input cyc_t c);
      rst_n        = c.rst_n;
      imem_rvalid  = c.irv;
      dmem_rvalid  = c.drv;
      branch_taken = c.bt;
      cyc_idx++;
      @(negedge clk);
      if (c.chk) checkOutput(c);
      @(posedge clk);
      #1;
      if (!c.rst_n) model_instret = 32'd0;
      else if (c.e_pcwe) model_instret = model_instret + 32'd1;
   endtask

   task automatic runInstr(input logic [31:0] ins, input int il, input int dl, input logic bt,
                           input int rst_mem, output logic [1:0] tcause);
      cyc_t c;
      logic [6:0] op;
      logic [2:0] imm;
      logic a, b, legal;
      logic [1:0] wb;
      op = ins[6:0];
      decodeOp(op, imm, a, b, wb, legal);
      tcause = 2'd0;
      cyc_idx = 0; obs_pcwe_cycle = 0; obs_dreq = 0; obs_ireq = 0; obs_regwe = 0; obs_pcsrc = 0;
      instr = ins;
      for (int k = 1; k <= T; k++) begin
         c = blank();
         c.e_ireq = 1'b1;
         c.irv    = (k == il);
         c.e_irwe = (k == il);
         applyStimulus(c);
         if (k == il) break;
      end
      if (il > T) begin tcause = 2'd2; return; end
      c = withFields(blank(), op);
      applyStimulus(c);
      if (!legal) begin tcause = 2'd1; return; end
      c = withFields(blank(), op);
      if (op == OP_BRANCH) begin
         c.bt = bt; c.e_pcwe = 1'b1; c.e_pcsrc = {1'b0, bt};
         applyStimulus(c);
         return;
      end
      applyStimulus(c);
      if (op == OP_LOAD || op == OP_STORE) begin
         for (int k = 1; k <= T; k++) begin
            c = withFields(blank(), op);
            c.e_dreq = 1'b1;
            c.e_dwe  = (op == OP_STORE);
            c.drv    = (k == dl);
            if (k == rst_mem && k != dl) begin
               c.rst_n = 1'b0;
               applyStimulus(c);
               return;
            end
            if (k == dl && op == OP_STORE) c.e_pcwe = 1'b1;
            applyStimulus(c);
            if (k == dl) break;
         end
         if (dl > T) begin tcause = 2'd2; return; end
         if (op == OP_STORE) return;
      end
      c = withFields(blank(), op);
      c.e_pcwe  = 1'b1;
      c.e_regwe = (ins[11:7] != 5'd0);
      c.e_pcsrc = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
      applyStimulus(c);
   endtask

   task automatic runTrap(input logic [1:0] cause, input int n);
      cyc_t c;
      obs_ireq = 0;
      for (int k = 0; k < n; k++) begin
         c = blank();
         c.e_trap  = 1'b1;
         c.e_cause = cause;
         applyStimulus(c);
      end
   endtask

   task automatic doReset(input int n);
      cyc_t c;
      for (int k = 0; k < n; k++) begin
         c = blank();
         c.rst_n = 1'b0;
         c.chk   = 1'b0;
         applyStimulus(c);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] tc;
      logic [6:0] legal_ops [9];
      logic [6:0] bad_ops [4];
      logic [31:0] r, ins;
      int il, dl, rm;
      legal_ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
      bad_ops   = '{7'h7F, 7'h00, 7'h0F, 7'h73};
      rst_n = 1'b0; instr = 32'd0; imem_rvalid = 0; dmem_rvalid = 0; branch_taken = 0;
      @(posedge clk);
      #1;
      doReset(2);

      $display("[TB] directed: ADDI x1,x0,5");
      runInstr(32'h00500093, 1, 0, 1'b0, 0, tc);
      checkLiteral("addi_pcwe_cycle", obs_pcwe_cycle, 4);
      checkLiteral("addi_reg_we", obs_regwe, 1);
      checkLiteral("addi_instret", instret, 1);

      $display("[TB] directed: LW x2,0(x1)");
      runInstr(32'h0000A103, 1, 3, 1'b0, 0, tc);
      checkLiteral("lw_dmem_req_cycles", obs_dreq, 3);
      checkLiteral("lw_reg_we", obs_regwe, 1);
      checkLiteral("lw_instret", instret, 2);

      $display("[TB] directed: BEQ taken / not taken");
      runInstr(32'h00000463, 1, 0, 1'b1, 0, tc);
      checkLiteral("beq_taken_pc_src", obs_pcsrc, 1);
      checkLiteral("beq_taken_reg_we", obs_regwe, 0);
      checkLiteral("beq_taken_pcwe_cycle", obs_pcwe_cycle, 3);
      runInstr(32'h00000463, 2, 0, 1'b0, 0, tc);
      checkLiteral("beq_nt_pc_src", obs_pcsrc, 0);

      $display("[TB] directed: illegal opcode");
      runInstr(32'h0000007F, 1, 0, 1'b0, 0, tc);
      runTrap(tc, 20);
      checkLiteral("illegal_cause", trap_cause, 1);
      checkLiteral("illegal_no_imem_req", obs_ireq, 0);
      doReset(1);

      $display("[TB] directed: fetch timeout and last-cycle response");
      runInstr(32'h00500093, T + 1, 0, 1'b0, 0, tc);
      checkLiteral("timeout_cause_model", tc, 2);
      runTrap(tc, 5);
      checkLiteral("timeout_cause", trap_cause, 2);
      doReset(1);
      runInstr(32'h00500093, T, 0, 1'b0, 0, tc);
      checkLiteral("late_rvalid_pcwe_cycle", obs_pcwe_cycle, T + 3);
      checkLiteral("late_rvalid_trap", trap, 0);

      $display("[TB] directed: reset during store MEM");
      runInstr(32'h00112023, 1, 10, 1'b0, 2, tc);
      checkLiteral("sw_reset_no_pcwe", obs_pcwe_cycle, 0);
      runInstr(32'h00500093, 2, 0, 1'b0, 0, tc);
      checkLiteral("after_reset_imem_req", obs_first_ireq, 1);
      checkLiteral("after_reset_dmem_req", obs_first_dreq, 0);
      checkLiteral("after_reset_instret", obs_first_instret, 0);

      $display("[TB] random instruction stream");
      for (int n = 0; n < 120; n++) begin
         r = $urandom();
         if ($urandom_range(0, 14) == 0) ins = {r[31:7], bad_ops[$urandom_range(0, 3)]};
         else ins = {r[31:7], legal_ops[$urandom_range(0, 8)]};
         il = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(1, T);
         dl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(1, T);
         if ($urandom_range(0, 19) == 0) il = T + 1;
         if ($urandom_range(0, 19) == 0) dl = T + 1;
         rm = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0;
         runInstr(ins, il, dl, 1'($urandom_range(0, 1)), rm, tc);
         if (tc != 2'd0) begin
            runTrap(tc, $urandom_range(2, 6));
            doReset($urandom_range(1, 2));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
